board_eval: RTL and testbench



---
 rtl/board_eval.sv | 167 ++++++++++++++++
 tb/tb_board_eval.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_eval.sv
// Material evaluator: walks N boards of NUM_SQUARES piece codes in SDRAM, writes one signed
// score word per board and tracks the best-scoring board for the search controller.
module board_eval #(
  parameter int NUM_SQUARES = 64,
  parameter int KING_VALUE  = 20000,
  parameter bit MAXIMIZE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CHECK, S_RD_REQ, S_RD_WAIT, S_ACCUM, S_WR_SCORE, S_DONE
  } state_t;

  localparam logic [31:0] BEST_INIT = MAXIMIZE ? 32'h8000_0000 : 32'h7FFF_FFFF;
  localparam logic [31:0] LAST_SQ   = 32'(NUM_SQUARES - 1);

  state_t             state, state_next;
  logic [31:0]        src, count, dst, best_idx, k, i;
  logic signed [31:0] best_score, acc;
  logic               error;
  logic [7:0]         piece, piece_mag;
  logic signed [31:0] mag_val, piece_val;
  logic               piece_bad;
  logic               busy, start, wr_en, better;
  logic               unused_ok;

  assign busy  = (state != S_IDLE) && (state != S_DONE);
  assign wr_en = slave_write && !busy;
  assign start = wr_en && (slave_address == 4'd0);

  // Piece codes are signed bytes; the magnitude band selects the material value.
  assign piece_mag = piece[7] ? (~piece + 8'd1) : piece;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mag_val   = '0;
    piece_bad = 1'b0;
    if (piece_mag == 8'd0)       mag_val = 32'sd0;
    else if (piece_mag <= 8'd8)  mag_val = 32'sd100;
    else if (piece_mag <= 8'd18) mag_val = 32'sd500;
    else if (piece_mag <= 8'd28) mag_val = 32'sd320;
    else if (piece_mag <= 8'd38) mag_val = 32'sd330;
    else if (piece_mag <= 8'd47) mag_val = 32'sd900;
    else if (piece_mag == 8'd48) mag_val = 32'(KING_VALUE);
    else                         piece_bad = 1'b1;
    piece_val = piece[7] ? -mag_val : mag_val;
  end

  assign better = MAXIMIZE ? (acc > best_score) : (acc < best_score);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: state_next = start ? S_INIT : S_IDLE;
      S_INIT:         state_next = S_CHECK;
      S_CHECK:        state_next = (k == count) ? S_DONE : S_RD_REQ;
      S_RD_REQ:       if (!master_waitrequest) state_next = S_RD_WAIT;
      S_RD_WAIT:      if (master_readdatavalid) state_next = S_ACCUM;
      S_ACCUM:        state_next = (i == LAST_SQ) ? S_WR_SCORE : S_RD_REQ;
      S_WR_SCORE:     if (!master_waitrequest) state_next = S_CHECK;
      default:        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    master_read      = (state == S_RD_REQ);
    master_write     = (state == S_WR_SCORE);
    master_address   = '0;
    master_writedata = '0;
    if (master_read)  master_address = src + k * 32'(NUM_SQUARES) + i;
    if (master_write) begin
      master_address   = dst + {k[29:0], 2'b00};
      master_writedata = acc;
    end
  end

  // Status reads stall while busy; every other register answers in the same cycle.
  assign slave_waitrequest = slave_read && (slave_address == 4'd0) && busy;

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = {31'b0, !busy};
        4'd1:    slave_readdata = src;
        4'd2:    slave_readdata = count;
        4'd3:    slave_readdata = dst;
        4'd4:    slave_readdata = best_idx;
        4'd5:    slave_readdata = best_score;
        4'd6:    slave_readdata = {31'b0, error};
        default: slave_readdata = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      src        <= '0;
      count      <= '0;
      dst        <= '0;
      best_idx   <= '1;
      best_score <= BEST_INIT;
      error      <= 1'b0;
      k          <= '0;
      i          <= '0;
      acc        <= '0;
      piece      <= '0;
    end else begin
      state <= state_next;
      if (wr_en) begin
        case (slave_address)
          4'd1:    src   <= slave_writedata;
          4'd2:    count <= slave_writedata;
          4'd3:    dst   <= slave_writedata;
          default: ;
        endcase
      end
      case (state)
        S_INIT: begin
          k          <= '0;
          i          <= '0;
          acc        <= '0;
          error      <= 1'b0;
          best_idx   <= '1;
          best_score <= BEST_INIT;
        end
        S_RD_WAIT: if (master_readdatavalid) piece <= master_readdata[7:0];
        S_ACCUM: begin
          acc <= acc + piece_val;
          if (piece_bad) error <= 1'b1;
          if (i != LAST_SQ) i <= i + 32'd1;
        end
        S_WR_SCORE: if (!master_waitrequest) begin
          // Strict compare: on a tie the earlier board keeps the title.
          if (better) begin
            best_idx   <= k;
            best_score <= acc;
          end
          k   <= k + 32'd1;
          i   <= '0;
          acc <= '0;
        end
        default: ;
      endcase
    end
  end

  assign unused_ok = ^{master_readdata[31:8], 1'b0};

endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval: an SDRAM responder model with optional stalls and read
// latency feeds two instances (maximising and minimising) that share one bus model.
module tb_board_eval;

  localparam logic [31:0] SCORE_M900  = 32'hFFFF_FC7C;  // -900
  localparam logic [31:0] SCORE_BOUND = 32'hFFFF_BB40;  // -17600

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic [3:0]  s_addr = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_wdata = '0;
  logic        s_wait0, s_wait1, s_wait;
  logic [31:0] s_rdata0, s_rdata1, s_rdata;

  logic        m_wait = 1'b0, m_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_read0, m_read1, m_write0, m_write1, m_read, m_write;
  logic [31:0] m_addr0, m_addr1, m_wdata0, m_wdata1, m_addr, m_wdata;

  board_eval dut_max (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(s_wait0), .slave_address(s_addr), .slave_read(s_read && !sel),
    .slave_readdata(s_rdata0), .slave_write(s_write && !sel), .slave_writedata(s_wdata),
    .master_waitrequest(m_wait), .master_address(m_addr0), .master_read(m_read0),
    .master_readdata(m_rdata), .master_readdatavalid(m_valid), .master_write(m_write0),
    .master_writedata(m_wdata0)
  );

  board_eval #(.MAXIMIZE(1'b0)) dut_min (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(s_wait1), .slave_address(s_addr), .slave_read(s_read && sel),
    .slave_readdata(s_rdata1), .slave_write(s_write && sel), .slave_writedata(s_wdata),
    .master_waitrequest(m_wait), .master_address(m_addr1), .master_read(m_read1),
    .master_readdata(m_rdata), .master_readdatavalid(m_valid), .master_write(m_write1),
    .master_writedata(m_wdata1)
  );

  assign s_wait  = sel ? s_wait1  : s_wait0;
  assign s_rdata = sel ? s_rdata1 : s_rdata0;
  assign m_read  = sel ? m_read1  : m_read0;
  assign m_write = sel ? m_write1 : m_write0;
  assign m_addr  = sel ? m_addr1  : m_addr0;
  assign m_wdata = sel ? m_wdata1 : m_wdata0;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- SDRAM responder model ----------------
  logic [7:0]  mem [0:1023];
  bit          stall_mode = 1'b0;
  int          rd_delay = 0;
  int          stall_left = 0, resp_cnt = 0, viol = 0;
  bit          resp_pend = 1'b0, prev_stalled = 1'b0;
  logic [7:0]  resp_data = '0;
  logic [31:0] prev_addr = '0;
  logic [31:0] rd_addrs[$], wr_addrs[$], wr_datas[$];

  // Inputs for the next rising edge are decided on the falling edge.
  always @(negedge clk) begin
    m_valid = 1'b0;
    if (!rst_n) begin
      resp_pend    = 1'b0;
      m_wait       = 1'b0;
      prev_stalled = 1'b0;
      stall_left   = 0;
    end else begin
      if (resp_pend) begin
        if (resp_cnt == 0) begin
          m_valid   = 1'b1;
          m_rdata   = {24'h0, resp_data};
          resp_pend = 1'b0;
        end else resp_cnt--;
      end
      if (m_read && m_write) viol++;
      if (prev_stalled && (!(m_read || m_write) || m_addr !== prev_addr)) viol++;
      prev_stalled = 1'b0;
      if (m_read || m_write) begin
        if (m_read && resp_pend) viol++;
        if (stall_left > 0) begin
          m_wait       = 1'b1;
          stall_left--;
          prev_stalled = 1'b1;
          prev_addr    = m_addr;
        end else begin
          m_wait     = 1'b0;
          stall_left = stall_mode ? int'($urandom_range(5, 1)) : 0;
          if (m_read) begin
            rd_addrs.push_back(m_addr);
            resp_pend = 1'b1;
            resp_cnt  = rd_delay;
            resp_data = mem[m_addr[9:0]];
          end else begin
            wr_addrs.push_back(m_addr);
            wr_datas.push_back(m_wdata);
          end
        end
      end else m_wait = 1'b0;
    end
  end

  // ---------------- board images ----------------
  task automatic load_start(input int base);
    int back [8] = '{9, 19, 29, 39, 48, 30, 20, 10};
    for (int sq = 0; sq < 64; sq++) mem[base + sq] = 8'h00;
    for (int j = 0; j < 8; j++) begin
      mem[base + j]      = 8'(back[j]);
      mem[base + 8 + j]  = 8'(j + 1);
      mem[base + 48 + j] = 8'(-(j + 1));
      mem[base + 56 + j] = 8'(-back[j]);
    end
  endtask

  task automatic load_boards();
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    load_start(0);
    load_start(256);
    mem[256 + 48] = 8'h00;                      // black pawn removed: +100
    load_start(320);
    mem[320 + 3] = 8'h00;                       // white queen removed: -900
    mem[512 + 0] = 8'd8;   mem[512 + 1] = 8'd9;  mem[512 + 2] = 8'd18;
    mem[512 + 3] = 8'd19;  mem[512 + 4] = 8'd28; mem[512 + 5] = 8'd29;
    mem[512 + 6] = 8'd38;  mem[512 + 7] = 8'd47;
    mem[512 + 8] = 8'hD0;  mem[512 + 9] = 8'hD1; // -48 and -47
    load_start(576);
    mem[576 + 20] = 8'h40;                      // illegal +64
  endtask

  // ---------------- slave bus ----------------
  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    s_addr = a; s_wdata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d, output int waits);
    @(negedge clk);
    s_addr = a; s_read = 1'b1; waits = 0;
    #1;
    while (s_wait === 1'b1 && waits < 20000) begin
      @(negedge clk);
      #1;
      waits++;
    end
    d = s_rdata;
    @(negedge clk);
    s_read = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] n, input logic [31:0] dst,
                         output logic [31:0] status);
    int w;
    reg_write(4'd1, src);
    reg_write(4'd2, n);
    reg_write(4'd3, dst);
    reg_write(4'd0, 32'h0);
    reg_read(4'd0, status, w);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    int w;
    pulse_reset();
    sel = 1'b0;
    vectors++;
    if (m_read0 !== 1'b0 || m_write0 !== 1'b0) begin
      miscompares++; $display("FAIL reset_master: read=%b write=%b expected 0 0", m_read0, m_write0);
    end
    reg_read(4'd0, d, w); vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL reset_status: got %h expected 00000001", d); end
    reg_read(4'd4, d, w); vectors++;
    if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_best_idx: got %h expected ffffffff", d); end
    reg_read(4'd5, d, w); vectors++;
    if (d !== 32'h8000_0000) begin miscompares++; $display("FAIL reset_best_score: got %h expected 80000000", d); end
    reg_read(4'd6, d, w); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_error: got %h expected 00000000", d); end
    reg_read(4'd9, d, w); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_reg9: got %h expected 00000000", d); end
    sel = 1'b1;
    reg_read(4'd5, d, w); vectors++;
    if (d !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL reset_best_score_min: got %h expected 7fffffff", d); end
    sel = 1'b0;
  endtask

  task automatic test_start_position();
    logic [31:0] d, got;
    int w, rb, wb, bad;
    sel = 1'b0;
    rb = rd_addrs.size(); wb = wr_addrs.size();
    run_job(32'd0, 32'd1, 32'h400, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL start_done: got %h expected 00000001", d); end
    vectors++;
    if (rd_addrs.size() - rb != 64) begin
      miscompares++; $display("FAIL start_read_count: got %0d expected 64", rd_addrs.size() - rb);
    end else begin
      bad = 0;
      for (int j = 0; j < 64; j++) if (rd_addrs[rb + j] !== 32'(j)) bad++;
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL start_read_order: %0d addresses off, expected 0", bad); end
    end
    vectors++;
    if (wr_addrs.size() - wb != 1) begin
      miscompares++; $display("FAIL start_write_count: got %0d expected 1", wr_addrs.size() - wb);
    end else begin
      got = wr_addrs[wb]; vectors++;
      if (got !== 32'h400) begin miscompares++; $display("FAIL start_write_addr: got %h expected 00000400", got); end
      got = wr_datas[wb]; vectors++;
      if (got !== 32'h0) begin miscompares++; $display("FAIL start_score: got %h expected 00000000", got); end
    end
    reg_read(4'd4, d, w); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL start_best_idx: got %h expected 00000000", d); end
    reg_read(4'd5, d, w); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL start_best_score: got %h expected 00000000", d); end
  endtask

  task automatic check_two_scores(input string tag, input int wb);
    vectors++;
    if (wr_addrs.size() - wb != 2) begin
      miscompares++; $display("FAIL %s_write_count: got %0d expected 2", tag, wr_addrs.size() - wb);
    end else begin
      vectors++;
      if (wr_addrs[wb] !== 32'h400 || wr_datas[wb] !== 32'd100) begin
        miscompares++; $display("FAIL %s_board0: got %h@%h expected 00000064@00000400", tag, wr_datas[wb], wr_addrs[wb]);
      end
      vectors++;
      if (wr_addrs[wb + 1] !== 32'h404 || wr_datas[wb + 1] !== SCORE_M900) begin
        miscompares++; $display("FAIL %s_board1: got %h@%h expected %h@00000404", tag, wr_datas[wb + 1], wr_addrs[wb + 1], SCORE_M900);
      end
    end
  endtask

  task automatic test_two_boards();
    logic [31:0] d;
    int w, wb;
    sel = 1'b0;
    wb = wr_addrs.size();
    reg_write(4'd1, 32'd256);
    reg_write(4'd2, 32'd2);
    reg_write(4'd3, 32'h400);
    reg_write(4'd0, 32'h0);
    reg_write(4'd2, 32'd7);                    // busy: must be ignored
    reg_read(4'd4, d, w); vectors++;
    if (w != 0) begin miscompares++; $display("FAIL busy_reg4_stall: got %0d wait cycles expected 0", w); end
    reg_read(4'd0, d, w); vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL two_done: got %h expected 00000001", d); end
    check_two_scores("two", wb);
    reg_read(4'd4, d, w); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL two_best_idx: got %h expected 00000000", d); end
    reg_read(4'd5, d, w); vectors++;
    if (d !== 32'd100) begin miscompares++; $display("FAIL two_best_score: got %h expected 00000064", d); end
    reg_read(4'd2, d, w); vectors++;
    if (d !== 32'd2) begin miscompares++; $display("FAIL busy_write_ignored: got %h expected 00000002", d); end
  endtask

  task automatic test_minimize();
    logic [31:0] d;
    int w, wb;
    sel = 1'b1;
    wb = wr_addrs.size();
    run_job(32'd256, 32'd2, 32'h400, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL min_done: got %h expected 00000001", d); end
    check_two_scores("min", wb);
    reg_read(4'd4, d, w); vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL min_best_idx: got %h expected 00000001", d); end
    reg_read(4'd5, d, w); vectors++;
    if (d !== SCORE_M900) begin miscompares++; $display("FAIL min_best_score: got %h expected %h", d, SCORE_M900); end
    sel = 1'b0;
  endtask

  task automatic test_stalls();
    logic [31:0] d;
    int rb, wb, v0;
    sel = 1'b0;
    stall_mode = 1'b1; rd_delay = 3;
    rb = rd_addrs.size(); wb = wr_addrs.size(); v0 = viol;
    run_job(32'd256, 32'd2, 32'h400, d);
    stall_mode = 1'b0; rd_delay = 0;
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL stall_done: got %h expected 00000001", d); end
    vectors++;
    if (rd_addrs.size() - rb != 128) begin
      miscompares++; $display("FAIL stall_read_count: got %0d expected 128", rd_addrs.size() - rb);
    end
    check_two_scores("stall", wb);
    vectors++;
    if (viol != v0) begin miscompares++; $display("FAIL stall_protocol: got %0d violations expected 0", viol - v0); end
  endtask

  task automatic test_piece_values();
    logic [31:0] d;
    int w, wb;
    sel = 1'b0;
    wb = wr_addrs.size();
    run_job(32'd512, 32'd1, 32'h480, d);
    vectors++;
    if (wr_addrs.size() - wb != 1 || wr_datas[wr_datas.size() - 1] !== SCORE_BOUND) begin
      miscompares++; $display("FAIL bands_score: got %0d writes last %h expected 1 write %h",
                              wr_addrs.size() - wb, wr_datas[wr_datas.size() - 1], SCORE_BOUND);
    end
    reg_read(4'd5, d, w); vectors++;
    if (d !== SCORE_BOUND) begin miscompares++; $display("FAIL bands_best_score: got %h expected %h", d, SCORE_BOUND); end
    reg_read(4'd6, d, w); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL bands_error: got %h expected 00000000", d); end
  endtask

  task automatic test_error();
    logic [31:0] d;
    int w, wb;
    sel = 1'b0;
    wb = wr_addrs.size();
    run_job(32'd576, 32'd1, 32'h400, d);
    vectors++;
    if (wr_addrs.size() - wb != 1 || wr_datas[wr_datas.size() - 1] !== 32'h0) begin
      miscompares++; $display("FAIL error_score: got %0d writes last %h expected 1 write 00000000",
                              wr_addrs.size() - wb, wr_datas[wr_datas.size() - 1]);
    end
    reg_read(4'd6, d, w); vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL error_flag: got %h expected 00000001", d); end
    pulse_reset();
    reg_read(4'd6, d, w); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL error_cleared: got %h expected 00000000", d); end
  endtask

  task automatic test_zero_boards();
    logic [31:0] d;
    int w, rb, wb;
    sel = 1'b0;
    rb = rd_addrs.size(); wb = wr_addrs.size();
    reg_write(4'd2, 32'd0);
    reg_write(4'd0, 32'h0);
    reg_read(4'd0, d, w);
    vectors++;
    if (d !== 32'h1 || w > 3) begin
      miscompares++; $display("FAIL zero_done: got status %h after %0d waits expected 00000001 within 3", d, w);
    end
    vectors++;
    if (rd_addrs.size() != rb || wr_addrs.size() != wb) begin
      miscompares++; $display("FAIL zero_traffic: got %0d reads %0d writes expected 0 0",
                              rd_addrs.size() - rb, wr_addrs.size() - wb);
    end
    reg_read(4'd4, d, w); vectors++;
    if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL zero_best_idx: got %h expected ffffffff", d); end
  endtask

  task automatic test_reset_midboard();
    logic [31:0] d;
    int w, wb;
    sel = 1'b0;
    reg_write(4'd1, 32'd256);
    reg_write(4'd2, 32'd2);
    reg_write(4'd3, 32'h400);
    reg_write(4'd0, 32'h0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_read0 !== 1'b0 || m_write0 !== 1'b0) begin
      miscompares++; $display("FAIL midreset_master: read=%b write=%b expected 0 0", m_read0, m_write0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reg_read(4'd0, d, w); vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL midreset_status: got %h expected 00000001", d); end
    reg_read(4'd1, d, w); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL midreset_src: got %h expected 00000000", d); end
    repeat (8) @(negedge clk);                  // let any stale response drain
    wb = wr_addrs.size();
    run_job(32'd256, 32'd2, 32'h400, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL restart_done: got %h expected 00000001", d); end
    check_two_scores("restart", wb);
  endtask

  initial begin
    load_boards();
    test_reset();
    test_start_position();
    test_two_boards();
    test_minimize();
    test_stalls();
    test_piece_values();
    test_error();
    test_zero_boards();
    test_reset_midboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
